usb_annunciator: RTL and testbench

- Debug annunciator between a USB device core and a byte-serial UART transmitter, all in the clk48 domain.
- Watches USB core status strobes and turns each event into a short ASCII message.
- Streams each message one byte at a time on q/dv and advances on inc, which is the UART's byte-done pulse.
- Lets a host terminal trace enumeration activity without a logic analyser.

---
 rtl/usb_annunciator_if.sv | 10 +
 rtl/usb_annunciator.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_usb_annunciator.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_annunciator_if.sv
// Byte stream between the annunciator and a UART transmitter.
// q/dv present one byte; inc acknowledges that it was consumed.
interface usb_annunciator_if;
    logic [7:0] q;
    logic       dv;
    logic       inc;

    modport master (output q, output dv, input inc);
    modport slave  (input q, input dv, output inc);
endinterface

// File: rtl/usb_annunciator.sv
// USB core event annunciator: turns status strobes into ASCII lines.
// Define USB_ANN_TXMON_EN to add the tx_en rise (X) message class.
module usb_annunciator #(
    parameter bit CRLF = 1'b1
) (
    input  logic                      clk48,
    input  logic                      rst_n,
    usb_annunciator_if.master         ser,
    input  logic                      tx_en,
    input  logic                      tx_j,
    input  logic                      tx_se0,
    input  logic                      usb_rst,
    input  logic                      transaction_active,
    input  logic [3:0]                endpoint,
    input  logic                      direction_in,
    input  logic                      setup,
    input  logic                      data_strobe,
    input  logic                      success
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT
    } state_t;

    localparam logic [7:0] TERM0 = CRLF ? 8'h0D : 8'h0A;
    localparam logic [7:0] TERM1 = 8'h0A;
    localparam logic [2:0] TLEN  = CRLF ? 3'd2 : 3'd1;

    function automatic logic [7:0] hex_char(input logic [3:0] v);
        return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
    endfunction

    state_t      state_q, state_d;
    logic        rst_h_q, rst_h_d;
    logic        ta_h_q, ta_h_d;
    logic        ok_h_q, ok_h_d;
    logic        pend_r_q, pend_r_d;
    logic        pend_t_q, pend_t_d;
    logic        pend_e_q, pend_e_d;
    logic        pend_k_q, pend_k_d;
    logic [3:0]  ep_q, ep_d;
    logic        dir_q, dir_d;
    logic        stp_q, stp_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  ecnt_q, ecnt_d;
    logic [7:0]  msg_q [0:5];
    logic [7:0]  msg_d [0:5];
    logic [2:0]  len_q, len_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  q_q, q_d;
    logic        dv_q, dv_d;

    logic        r_rise, t_rise, e_rise, k_rise;
    logic        x_pend;
    logic        load;
    logic        take_r, take_t, take_e, take_k, take_x;
    logic [7:0]  new_msg [0:5];
    logic [2:0]  new_len;

`ifdef USB_ANN_TXMON_EN
    logic        txen_h_q, txen_h_d;
    logic        pend_x_q, pend_x_d;
    logic [7:0]  xch_q, xch_d;
    logic        x_rise;

    assign x_rise = tx_en & ~txen_h_q;
    assign x_pend = pend_x_q;

    always_comb begin
        txen_h_d = tx_en;
        pend_x_d = (pend_x_q & ~take_x) | x_rise;
        xch_d    = xch_q;
        // A capture is only replaced once the previous one has gone out
        if (x_rise && (!pend_x_q || take_x)) begin
            if (tx_se0) begin
                xch_d = "S";
            end else if (tx_j) begin
                xch_d = "J";
            end else begin
                xch_d = "K";
            end
        end
    end

    always_ff @(posedge clk48) begin
        if (!rst_n) begin
            txen_h_q <= 1'b0;
            pend_x_q <= 1'b0;
            xch_q    <= 8'h00;
        end else begin
            txen_h_q <= txen_h_d;
            pend_x_q <= pend_x_d;
            xch_q    <= xch_d;
        end
    end
`else
    logic unused_tx;

    assign unused_tx = tx_en ^ tx_j ^ tx_se0;
    assign x_pend    = 1'b0;
`endif

    assign r_rise = usb_rst & ~rst_h_q;
    assign t_rise = transaction_active & ~ta_h_q;
    assign e_rise = ~transaction_active & ta_h_q;
    assign k_rise = success & ~ok_h_q;

    assign load = (state_q == S_IDLE) &&
                  (pend_r_q || pend_t_q || pend_e_q || pend_k_q || x_pend);

    // Fixed priority R > T > E > K > X
    assign take_r = load & pend_r_q;
    assign take_t = load & ~pend_r_q & pend_t_q;
    assign take_e = load & ~pend_r_q & ~pend_t_q & pend_e_q;
    assign take_k = load & ~pend_r_q & ~pend_t_q & ~pend_e_q & pend_k_q;
    assign take_x = load & ~pend_r_q & ~pend_t_q & ~pend_e_q & ~pend_k_q
                    & x_pend;

    always_comb begin
        rst_h_d  = usb_rst;
        ta_h_d   = transaction_active;
        ok_h_d   = success;
        pend_r_d = (pend_r_q & ~take_r) | r_rise;
        pend_t_d = (pend_t_q & ~take_t) | t_rise;
        pend_e_d = (pend_e_q & ~take_e) | e_rise;
        pend_k_d = (pend_k_q & ~take_k) | k_rise;
        ep_d     = ep_q;
        dir_d    = dir_q;
        stp_d    = stp_q;
        ecnt_d   = ecnt_q;
        cnt_d    = cnt_q;
        if (t_rise && (!pend_t_q || take_t)) begin
            ep_d  = endpoint;
            dir_d = direction_in;
            stp_d = setup;
        end
        if (e_rise && (!pend_e_q || take_e)) begin
            ecnt_d = cnt_q;
        end
        if (t_rise) begin
            cnt_d = {7'h00, data_strobe};
        end else if (transaction_active && data_strobe && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'h01;
        end
    end

    always_comb begin
        for (int i = 0; i < 6; i++) begin
            new_msg[i] = 8'h00;
        end
        new_len = 3'd0;
        unique case (1'b1)
            take_r: begin
                new_msg[0] = "R";
                new_msg[1] = TERM0;
                new_msg[2] = TERM1;
                new_len    = 3'd1 + TLEN;
            end
            take_t: begin
                new_msg[0] = "T";
                new_msg[1] = hex_char(ep_q);
                new_msg[2] = dir_q ? "I" : "O";
                new_msg[3] = stp_q ? "S" : "-";
                new_msg[4] = TERM0;
                new_msg[5] = TERM1;
                new_len    = 3'd4 + TLEN;
            end
            take_e: begin
                new_msg[0] = "E";
                new_msg[1] = hex_char(ecnt_q[7:4]);
                new_msg[2] = hex_char(ecnt_q[3:0]);
                new_msg[3] = TERM0;
                new_msg[4] = TERM1;
                new_len    = 3'd3 + TLEN;
            end
            take_k: begin
                new_msg[0] = "O";
                new_msg[1] = "K";
                new_msg[2] = TERM0;
                new_msg[3] = TERM1;
                new_len    = 3'd2 + TLEN;
            end
`ifdef USB_ANN_TXMON_EN
            take_x: begin
                new_msg[0] = "X";
                new_msg[1] = xch_q;
                new_msg[2] = TERM0;
                new_msg[3] = TERM1;
                new_len    = 3'd2 + TLEN;
            end
`endif
            default: begin
                new_len = 3'd0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        q_d     = q_q;
        dv_d    = 1'b0;
        msg_d   = msg_q;
        unique case (state_q)
            S_IDLE: begin
                if (load) begin
                    msg_d   = new_msg;
                    len_d   = new_len;
                    idx_d   = 3'd0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                q_d     = msg_q[idx_q];
                dv_d    = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (ser.inc) begin
                    if (idx_q == len_q - 3'd1) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_SEND;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk48) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rst_h_q  <= 1'b0;
            ta_h_q   <= 1'b0;
            ok_h_q   <= 1'b0;
            pend_r_q <= 1'b0;
            pend_t_q <= 1'b0;
            pend_e_q <= 1'b0;
            pend_k_q <= 1'b0;
            ep_q     <= 4'h0;
            dir_q    <= 1'b0;
            stp_q    <= 1'b0;
            cnt_q    <= 8'h00;
            ecnt_q   <= 8'h00;
            msg_q    <= '{default: 8'h00};
            len_q    <= 3'd0;
            idx_q    <= 3'd0;
            q_q      <= 8'h00;
            dv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rst_h_q  <= rst_h_d;
            ta_h_q   <= ta_h_d;
            ok_h_q   <= ok_h_d;
            pend_r_q <= pend_r_d;
            pend_t_q <= pend_t_d;
            pend_e_q <= pend_e_d;
            pend_k_q <= pend_k_d;
            ep_q     <= ep_d;
            dir_q    <= dir_d;
            stp_q    <= stp_d;
            cnt_q    <= cnt_d;
            ecnt_q   <= ecnt_d;
            msg_q    <= msg_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            q_q      <= q_d;
            dv_q     <= dv_d;
        end
    end

    assign ser.q  = q_q;
    assign ser.dv = dv_q;

endmodule

// File: tb/tb_usb_annunciator.sv
// Directed bench for usb_annunciator: a UART-like responder answers
// every dv with inc five cycles later; received bytes are queued.
module tb_usb_annunciator;

    logic       clk48 = 1'b0;
    logic       rst_n;
    logic       tx_en = 1'b0;
    logic       tx_j = 1'b0;
    logic       tx_se0 = 1'b0;
    logic       usb_rst = 1'b0;
    logic       transaction_active = 1'b0;
    logic [3:0] endpoint = 4'h0;
    logic       direction_in = 1'b0;
    logic       setup = 1'b0;
    logic       data_strobe = 1'b0;
    logic       success = 1'b0;

    usb_annunciator_if bus();

    usb_annunciator #(.CRLF(1'b1)) dut (
        .clk48              (clk48),
        .rst_n              (rst_n),
        .ser                (bus.master),
        .tx_en              (tx_en),
        .tx_j               (tx_j),
        .tx_se0             (tx_se0),
        .usb_rst            (usb_rst),
        .transaction_active (transaction_active),
        .endpoint           (endpoint),
        .direction_in       (direction_in),
        .setup              (setup),
        .data_strobe        (data_strobe),
        .success            (success)
    );

    always #5 clk48 = ~clk48;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] rx_q [$];
    int         rx_cyc [$];
    int         last_cyc = 0;
    int         proto_err = 0;
    logic       owed = 1'b0;
    logic       dv_prev = 1'b0;
    int         inc_cnt = 0;

    initial bus.inc = 1'b0;

    always @(posedge clk48) cyc++;

    // Receiver model: records bytes, flags protocol errors, answers with inc
    always @(negedge clk48) begin
        if (bus.inc) begin
            bus.inc = 1'b0;
            owed = 1'b0;
        end
        if (!rst_n) begin
            owed = 1'b0;
            inc_cnt = 0;
        end
        if (bus.dv) begin
            if (dv_prev) proto_err++;
            if (owed) proto_err++;
            owed = 1'b1;
            rx_q.push_back(bus.q);
            rx_cyc.push_back(cyc);
            inc_cnt = 5;
        end else if (inc_cnt > 0) begin
            inc_cnt--;
            if (inc_cnt == 0 && rst_n) bus.inc = 1'b1;
        end
        dv_prev = bus.dv;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk48);
    endtask

    task automatic get_byte(input logic [7:0] exp, input string tag,
                            input int budget);
        int n = 0;
        logic [7:0] got;
        while (rx_q.size() == 0 && n < budget) begin
            @(negedge clk48);
            #1;
            n++;
        end
        checks++;
        assert (rx_q.size() != 0) else begin
            errors++;
            $error("FAIL %s: no byte observed, expected %02h", tag, exp);
        end
        if (rx_q.size() != 0) begin
            got = rx_q.pop_front();
            last_cyc = rx_cyc.pop_front();
            assert (got === exp) else begin
                errors++;
                $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
            end
        end
    endtask

    task automatic expect_msg(input string body, input string tag);
        for (int i = 0; i < body.len(); i++) begin
            get_byte(body[i], tag, 200);
        end
        get_byte(8'h0D, {tag, "_cr"}, 200);
        get_byte(8'h0A, {tag, "_lf"}, 200);
    endtask

    task automatic expect_quiet(input int n, input string tag);
        step(n);
        #1;
        checks++;
        assert (rx_q.size() == 0) else begin
            errors++;
            $error("FAIL %s: observed %0d extra bytes expected 0",
                   tag, rx_q.size());
        end
        checks++;
        assert (proto_err == 0) else begin
            errors++;
            $error("FAIL %s_proto: observed %0d dv errors expected 0",
                   tag, proto_err);
        end
    endtask

    initial begin
        int c0;
        rst_n   = 1'b0;
        usb_rst = 1'b1;
        step(3);
        #1;
        checks++;
        assert (bus.q === 8'h00) else begin
            errors++;
            $error("FAIL rst_q: observed %02h expected 00", bus.q);
        end
        checks++;
        assert (bus.dv === 1'b0) else begin
            errors++;
            $error("FAIL rst_dv: observed %b expected 0", bus.dv);
        end

        // Release with usb_rst still high: history is 0, so one R line
        @(negedge clk48);
        rst_n = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk48);
            #1;
            checks++;
            assert (bus.dv === 1'b0) else begin
                errors++;
                $error("FAIL lat_dv%0d: observed %b expected 0", i, bus.dv);
            end
        end
        get_byte("R", "rel_R", 1);
        checks++;
        assert (last_cyc - c0 == 3) else begin
            errors++;
            $error("FAIL lat: observed %0d cycles expected 3", last_cyc - c0);
        end
        get_byte(8'h0D, "rel_cr", 200);
        get_byte(8'h0A, "rel_lf", 200);
        expect_quiet(30, "rel_quiet");
        usb_rst = 1'b0;
        step(3);

        // Single usb_rst pulse
        usb_rst = 1'b1;
        step(1);
        usb_rst = 1'b0;
        expect_msg("R", "pulse_R");
        expect_quiet(20, "pulse_quiet");

        // SETUP transaction on EP 0xA with three data bytes, then ACK
        endpoint = 4'hA;
        direction_in = 1'b0;
        setup = 1'b1;
        transaction_active = 1'b1;
        step(1);
        for (int i = 0; i < 3; i++) begin
            data_strobe = 1'b1;
            step(1);
            data_strobe = 1'b0;
            step(1);
        end
        transaction_active = 1'b0;
        step(1);
        success = 1'b1;
        step(1);
        success = 1'b0;
        expect_msg("TAOS", "txn_T");
        expect_msg("E03", "txn_E");
        expect_msg("OK", "txn_K");
        expect_quiet(20, "txn_quiet");

        // Strobe counter saturation
        endpoint = 4'h3;
        direction_in = 1'b1;
        setup = 1'b0;
        transaction_active = 1'b1;
        data_strobe = 1'b1;
        step(300);
        transaction_active = 1'b0;
        data_strobe = 1'b0;
        expect_msg("T3I-", "sat_T");
        expect_msg("EFF", "sat_E");
        expect_quiet(20, "sat_quiet");

        // Busy with OK; R and T rise together; second R pulse is dropped
        success = 1'b1;
        step(1);
        success = 1'b0;
        step(3);
        endpoint = 4'h5;
        direction_in = 1'b0;
        setup = 1'b0;
        usb_rst = 1'b1;
        transaction_active = 1'b1;
        step(1);
        usb_rst = 1'b0;
        step(1);
        usb_rst = 1'b1;
        step(1);
        usb_rst = 1'b0;
        step(2);
        transaction_active = 1'b0;
        expect_msg("OK", "pri_K");
        expect_msg("R", "pri_R");
        expect_msg("T5O-", "pri_T");
        expect_msg("E00", "pri_E");
        expect_quiet(30, "pri_quiet");

        // Reset after the second byte of TAOS aborts the line
        endpoint = 4'hA;
        direction_in = 1'b0;
        setup = 1'b1;
        transaction_active = 1'b1;
        get_byte("T", "abort_T", 50);
        get_byte("A", "abort_A", 50);
        rst_n = 1'b0;
        transaction_active = 1'b0;
        step(2);
        #1;
        checks++;
        assert (bus.dv === 1'b0) else begin
            errors++;
            $error("FAIL abort_dv: observed %b expected 0", bus.dv);
        end
        checks++;
        assert (bus.q === 8'h00) else begin
            errors++;
            $error("FAIL abort_q: observed %02h expected 00", bus.q);
        end
        rst_n = 1'b1;
        expect_quiet(40, "abort_quiet");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
